// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the CPU pipeline stages.
//   pc_sel_t      : next-PC select encoding driven by the branch comparator
//   fetch_state_t : fetch-stage sequencing state (BOOT after reset, then RUN)
//   DEFAULT_RESET_PC : PC loaded by reset unless a stage overrides it
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'b00,
    PC_SEL_BRANCH = 2'b01
  } pc_sel_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus plus IF/ID pipeline register outputs.
//   imem_addr   : fetch address (current PC), driven by the fetch stage
//   imem_rdata  : combinational instruction word for imem_addr
//   if_id_instr : IF/ID instruction
//   if_id_pc    : PC of if_id_instr
//   if_id_valid : IF/ID holds a real instruction (0 = bubble)
// master = fetch stage side, slave = memory / decode side.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
);

  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [PC_WIDTH-1:0]    if_id_pc;
  logic                   if_id_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output if_id_instr,
    output if_id_pc,
    output if_id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_valid
  );

endinterface

// File: rtl/pc_reg.sv
// pc_reg: program-counter register with synchronous active-high reset.
//   clk  : clock
//   rst  : synchronous reset, loads RESET_VAL
//   en   : load pc_d when high, hold otherwise
//   pc_d : next PC value
//   pc_q : current PC
module pc_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else if (en) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipelined CPU.
//   clk, rst      : clock and synchronous active-high reset
//   select_pc_mux : next-PC select (01 = taken branch, anything else = PC+1)
//   branch_target : redirect PC used on a taken branch
//   stall         : hazard stall, freezes PC, IF/ID and fetch_count
//   bus           : imem address/data and IF/ID register outputs
//   flush_id_ex   : squash the instruction entering ID/EX (taken branch)
//   fetch_count   : number of valid instructions loaded into IF/ID
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          select_pc_mux,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                stall,
  fetch_stage_if.master       bus,
  output logic                flush_id_ex,
  output logic [15:0]         fetch_count
);

  fetch_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   pc_en;
  logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
  logic [PC_WIDTH-1:0]    if_id_pc_q, if_id_pc_d;
  logic                   if_id_valid_q, if_id_valid_d;
  logic [15:0]            fetch_count_q, fetch_count_d;
  logic                   taken;

  // Codes 10/11 are not branch selects and fall through to sequential fetch.
  assign taken = (select_pc_mux == PC_SEL_BRANCH);

  pc_reg #(
    .WIDTH     (PC_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .en   (pc_en),
    .pc_d (pc_d),
    .pc_q (pc_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // A taken branch wins over stall: the branch is older than the stalled
  // instruction, so the wrong-path fetch is dropped and IF/ID becomes a bubble.
  always_comb begin
    pc_en         = 1'b0;
    pc_d          = pc_q + 1'b1;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    if (taken) begin
      pc_en         = 1'b1;
      pc_d          = branch_target;
      if_id_instr_d = '0;
      if_id_pc_d    = '0;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_en         = 1'b1;
      if_id_instr_d = bus.imem_rdata;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign flush_id_ex     = taken && !rst;
  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign fetch_count     = fetch_count_q;

endmodule
